cl_tst_cfg_resp: RTL and testbench

Config-bus responder: the target end of the per-test-block `cfg_bus_t` link driven by the OCL slave decoder. It accepts one-cycle `wr`/`rd` strobes and returns a one-cycle `ack` with read data. It holds a small register bank that controls a periodic trigger generator and counts completion and error events from the attached test engine. One instance sits inside each test block behind its 64 KB slot.

---
 rtl/cl_tst_cfg_resp_if.sv | 12 +
 rtl/cl_tst_cfg_resp.sv | 155 +++++++++++++++
 tb/tb_cl_tst_cfg_resp.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cl_tst_cfg_resp_if.sv
// rtl/cl_tst_cfg_resp_if.sv - config-bus link between the OCL slave decoder and a test-block responder
interface cl_tst_cfg_resp_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic        ack;
  logic [31:0] rdata;

  modport master (output addr, wdata, wr, rd, input ack, rdata);
  modport slave  (input addr, wdata, wr, rd, output ack, rdata);
endinterface

// File: rtl/cl_tst_cfg_resp.sv
// rtl/cl_tst_cfg_resp.sv - config-bus responder with trigger generator and event counters
module cl_tst_cfg_resp #(
  parameter logic [31:0] BLK_ID       = 32'h0001_0000,
  parameter int unsigned ACK_DLY      = 0,
  parameter logic [15:0] DEF_INTERVAL = 16'd255
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  cl_tst_cfg_resp_if.slave cfg,
  input  logic             tst_done,
  input  logic             tst_err,
  output logic             tst_run,
  output logic             tst_trig
);
  typedef enum logic {IDLE, PEND} hs_state_t;
  typedef enum logic {STOP, RUN}  run_state_t;

  localparam logic [3:0] DLY = 4'(ACK_DLY);

  hs_state_t   hs_state, hs_next;
  run_state_t  run_state, run_next;
  logic [3:0]  dly_cnt;
  logic        pend_rd;
  logic [31:0] snap;
  logic        enable, done_flag, err_flag, trig_q;
  logic [15:0] interval, timer;
  logic [31:0] done_cnt, run_cyc, scratch;
  logic [31:0] rd_mux;
  logic        hit, strobe, wr_en, rd_en, ctrl_wr, stat_wr, clr, go_run, halt;
  logic        ack_set, rd_load;
  logic [2:0]  idx;
  logic        unused_addr;

  assign unused_addr = ^{cfg.addr[31:16], cfg.addr[1:0]};

  assign hit     = (cfg.addr[15:5] == 11'd0);
  assign idx     = cfg.addr[4:2];
  assign strobe  = (hs_state == IDLE) && (cfg.wr || cfg.rd);
  assign wr_en   = (hs_state == IDLE) && cfg.wr;
  assign rd_en   = (hs_state == IDLE) && cfg.rd && !cfg.wr;
  assign ctrl_wr = wr_en && hit && (idx == 3'd0);
  assign stat_wr = wr_en && hit && (idx == 3'd1);
  assign clr     = ctrl_wr && cfg.wdata[2];
  // START counts the ENABLE bit carried in the same write; CLR always stops
  assign go_run  = ctrl_wr && cfg.wdata[1] && cfg.wdata[0] && !cfg.wdata[2];
  assign halt    = ctrl_wr && (!cfg.wdata[0] || cfg.wdata[2]);

  always_comb begin
    rd_mux = 32'hDEAD_BEEF;
    if (hit) begin
      case (idx)
        3'd0:    rd_mux = {31'd0, enable};
        3'd1:    rd_mux = {29'd0, err_flag, done_flag, run_state == RUN};
        3'd2:    rd_mux = {16'd0, interval};
        3'd3:    rd_mux = done_cnt;
        3'd4:    rd_mux = run_cyc;
        3'd5:    rd_mux = scratch;
        3'd6:    rd_mux = BLK_ID;
        default: rd_mux = {16'd0, timer};
      endcase
    end
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      hs_state  <= IDLE;
      run_state <= STOP;
    end else begin
      hs_state  <= hs_next;
      run_state <= run_next;
    end
  end

  always_comb begin
    hs_next = hs_state;
    case (hs_state)
      IDLE:    if (strobe) hs_next = PEND;
      default: if (dly_cnt == 4'd0) hs_next = IDLE;
    endcase
  end

  always_comb begin
    run_next = run_state;
    case (run_state)
      STOP:    if (go_run) run_next = RUN;
      default: if (halt) run_next = STOP;
    endcase
  end

  // ack and rdata are registered, so they are set up one cycle before the ack cycle
  always_comb begin
    ack_set = 1'b0;
    rd_load = 1'b0;
    if (hs_state == IDLE) begin
      ack_set = strobe && (DLY == 4'd0);
      rd_load = rd_en && (DLY == 4'd0);
    end else begin
      ack_set = (dly_cnt == 4'd1);
      rd_load = (dly_cnt == 4'd1) && pend_rd;
    end
  end

  assign tst_run  = (run_state == RUN);
  assign tst_trig = trig_q;

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      cfg.ack   <= 1'b0;
      cfg.rdata <= 32'd0;
      dly_cnt   <= 4'd0;
      pend_rd   <= 1'b0;
      snap      <= 32'd0;
    end else begin
      cfg.ack <= ack_set;
      if (rd_load) cfg.rdata <= (hs_state == IDLE) ? rd_mux : snap;
      if (strobe) begin
        dly_cnt <= DLY;
        pend_rd <= rd_en;
      end else if (hs_state == PEND && dly_cnt != 4'd0) begin
        dly_cnt <= dly_cnt - 4'd1;
      end
      if (rd_en) snap <= rd_mux;
    end
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      enable    <= 1'b0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
      interval  <= DEF_INTERVAL;
      scratch   <= 32'd0;
      done_cnt  <= 32'd0;
      run_cyc   <= 32'd0;
      timer     <= 16'd0;
      trig_q    <= 1'b0;
    end else begin
      if (ctrl_wr) enable <= cfg.wdata[0];
      if (wr_en && hit && idx == 3'd2) interval <= cfg.wdata[15:0];
      if (wr_en && hit && idx == 3'd5) scratch <= cfg.wdata;
      if (tst_done) done_flag <= 1'b1;
      else if (stat_wr && cfg.wdata[1]) done_flag <= 1'b0;
      if (tst_err) err_flag <= 1'b1;
      else if (stat_wr && cfg.wdata[2]) err_flag <= 1'b0;
      if (clr) done_cnt <= 32'd0;
      else if (tst_done && done_cnt != 32'hFFFF_FFFF) done_cnt <= done_cnt + 32'd1;
      if (clr) run_cyc <= 32'd0;
      else if (run_state == RUN) run_cyc <= run_cyc + 32'd1;
      if (halt) timer <= 16'd0;
      else if (go_run) timer <= interval;
      else if (run_state == RUN) timer <= (timer == 16'd0) ? interval : timer - 16'd1;
      trig_q <= (run_state == RUN) && !halt && !go_run && (timer == 16'd0);
    end
  end
endmodule

// File: tb/tb_cl_tst_cfg_resp.sv
// tb/tb_cl_tst_cfg_resp.sv - self-checking bench for cl_tst_cfg_resp
module tb_cl_tst_cfg_resp;
  localparam logic [31:0] ID0 = 32'h0001_0000;
  localparam logic [31:0] ID3 = 32'h0003_00C3;

  logic clk = 1'b0;
  logic sync_rst_n = 1'b0;
  logic done0 = 1'b0, err0 = 1'b0, done3 = 1'b0, err3 = 1'b0;
  logic run0, trig0, run3, trig3;
  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_scratch = 32'd0;
  logic [31:0] m_done_cnt = 32'd0;
  logic [15:0] m_interval = 16'd255;
  logic        m_done = 1'b0, m_err = 1'b0, m_enable = 1'b0;

  cl_tst_cfg_resp_if bus0();
  cl_tst_cfg_resp_if bus3();

  always #5 clk = ~clk;

  cl_tst_cfg_resp #(.BLK_ID(ID0), .ACK_DLY(0)) dut0 (
    .clk(clk), .sync_rst_n(sync_rst_n), .cfg(bus0.slave),
    .tst_done(done0), .tst_err(err0), .tst_run(run0), .tst_trig(trig0)
  );

  cl_tst_cfg_resp #(.BLK_ID(ID3), .ACK_DLY(3)) dut3 (
    .clk(clk), .sync_rst_n(sync_rst_n), .cfg(bus3.slave),
    .tst_done(done3), .tst_err(err3), .tst_run(run3), .tst_trig(trig3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[15:5] != 11'd0) return 32'hDEAD_BEEF;
    case (a[4:2])
      3'd0:    return {31'd0, m_enable};
      3'd1:    return {29'd0, m_err, m_done, 1'b0};
      3'd2:    return {16'd0, m_interval};
      3'd3:    return m_done_cnt;
      3'd5:    return m_scratch;
      3'd6:    return ID0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_done();
    m_done = 1'b1;
    if (m_done_cnt != 32'hFFFF_FFFF) m_done_cnt = m_done_cnt + 32'd1;
  endfunction

  task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic ev = 1'b0);
    @(negedge clk);
    bus0.addr = a; bus0.wdata = d; bus0.wr = 1'b1; done0 = ev;
    @(negedge clk);
    bus0.wr = 1'b0; done0 = 1'b0;
    chk("wr_ack", {31'd0, bus0.ack}, 32'd1);
  endtask

  task automatic rd0(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus0.addr = a; bus0.rd = 1'b1;
    @(negedge clk);
    bus0.rd = 1'b0;
    chk({tag, "_ack"}, {31'd0, bus0.ack}, 32'd1);
    chk(tag, bus0.rdata, exp);
    @(negedge clk);
    chk({tag, "_ack_once"}, {31'd0, bus0.ack}, 32'd0);
    chk({tag, "_hold"}, bus0.rdata, exp);
  endtask

  task automatic pulse0(input logic d, input logic e);
    @(negedge clk);
    done0 = d; err0 = e;
    @(negedge clk);
    done0 = 1'b0; err0 = 1'b0;
    if (d) model_done();
    if (e) m_err = 1'b1;
  endtask

  initial begin
    logic [31:0] a, d;
    logic        ev, exp_trig;
    int          op;

    bus0.addr = 0; bus0.wdata = 0; bus0.wr = 0; bus0.rd = 0;
    bus3.addr = 0; bus3.wdata = 0; bus3.wr = 0; bus3.rd = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, bus0.ack}, 32'd0);
    chk("rst_rdata", bus0.rdata, 32'd0);
    chk("rst_run", {31'd0, run0}, 32'd0);
    chk("rst_trig", {31'd0, trig0}, 32'd0);
    sync_rst_n = 1'b1;

    rd0(32'h08, 32'h0000_00FF, "rst_interval");
    rd0(32'h18, ID0, "rst_id");

    // delayed ack, with a write strobe one cycle later that must be dropped
    @(negedge clk);
    bus3.addr = 32'h18; bus3.rd = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus3.rd = 1'b0;
      bus3.wr = (c == 1);
      bus3.addr = (c == 1) ? 32'h14 : 32'h18;
      bus3.wdata = 32'h1234_5678;
      chk("dly_ack", {31'd0, bus3.ack}, {31'd0, c == 4});
      if (c >= 4) chk("dly_rdata", bus3.rdata, ID3);
    end
    @(negedge clk);
    bus3.addr = 32'h14; bus3.rd = 1'b1;
    @(negedge clk);
    bus3.rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("dly_drop_ack", {31'd0, bus3.ack}, 32'd1);
    chk("dly_drop_scratch", bus3.rdata, 32'd0);

    wr0(32'h14, 32'hA5A5_5A5A); m_scratch = 32'hA5A5_5A5A;
    rd0(32'h14, 32'hA5A5_5A5A, "scratch");
    rd0(32'h0100, 32'hDEAD_BEEF, "unmapped");

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 6);
      a = $urandom;
      d = $urandom;
      case (op)
        0: begin a[15:2] = {11'd0, 3'd5}; wr0(a, d); m_scratch = d; end
        1: begin a[15:2] = {11'd0, 3'd2}; wr0(a, d); m_interval = d[15:0]; end
        2: pulse0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        3: begin
          a[15:2] = {11'd0, 3'd1};
          ev = 1'($urandom_range(0, 1));
          wr0(a, d, ev);
          if (ev) model_done();
          else if (d[1]) m_done = 1'b0;
          if (d[2]) m_err = 1'b0;
        end
        4: begin a[15:5] = 11'($urandom_range(1, 2047)); wr0(a, d); end
        default: begin
          if ($urandom_range(0, 3) == 0) a[15:5] = 11'($urandom_range(1, 2047));
          else a[15:5] = 11'd0;
          rd0(a, model_read(a), "rand_rd");
        end
      endcase
    end
    rd0(32'h0C, m_done_cnt, "rand_done_cnt");
    rd0(32'h04, model_read(32'h04), "rand_status");

    wr0(32'h08, 32'd3); m_interval = 16'd3;
    @(negedge clk);
    bus0.addr = 32'h00; bus0.wdata = 32'h3; bus0.wr = 1'b1;
    m_enable = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      bus0.wr = 1'b0;
      exp_trig = (c >= 5) && ((c - 5) % 4 == 0);
      chk("trig_run", {31'd0, run0}, 32'd1);
      chk("trig_pulse", {31'd0, trig0}, {31'd0, exp_trig});
    end
    wr0(32'h00, 32'h0); m_enable = 1'b0;
    chk("stop_run", {31'd0, run0}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stop_trig", {31'd0, trig0}, 32'd0);
    end

    wr0(32'h08, 32'd0); m_interval = 16'd0;
    @(negedge clk);
    bus0.addr = 32'h00; bus0.wdata = 32'h3; bus0.wr = 1'b1;
    m_enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus0.wr = 1'b0;
      chk("int0_trig", {31'd0, trig0}, {31'd0, c >= 2});
    end

    wr0(32'h00, 32'h5, 1'b1);
    model_done();
    m_done_cnt = 32'd0;
    chk("clr_run", {31'd0, run0}, 32'd0);
    rd0(32'h0C, 32'd0, "clr_done_cnt");
    rd0(32'h10, 32'd0, "clr_run_cyc");
    rd0(32'h1C, 32'd0, "clr_timer");
    rd0(32'h04, model_read(32'h04), "clr_status");
    rd0(32'h00, 32'd1, "clr_ctrl");

    wr0(32'h04, 32'h2, 1'b1); model_done();
    rd0(32'h04, model_read(32'h04), "w1c_race");
    wr0(32'h04, 32'h6); m_done = 1'b0; m_err = 1'b0;
    rd0(32'h04, 32'd0, "w1c_clear");

    @(negedge clk);
    force dut0.done_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut0.done_cnt;
    m_done_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) pulse0(1'b1, 1'b0);
    rd0(32'h0C, m_done_cnt, "sat_done_cnt");
    rd0(32'h0C, 32'hFFFF_FFFF, "sat_limit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
